plan_act_pipe: RTL and testbench
================================

Name: plan_act_pipe

Overview:
- Pipelined piecewise-linear (PLAN) activation unit; the next generation of the single-function sigmoid block.
- Adds runtime per-sample mode select (sigmoid / tanh), a valid/ready handshake with full back-pressure, a pass-through tag, and parametrised fixed-point widths.
- Sits between the MAC accumulator output and the layer write-back buffer.

Parameters:
- IN_W, 32, input width, signed two's complement.
- IN_FRAC, 24, input fraction bits; default format is Q8.24.
- OUT_W, 16, output width, signed.
- OUT_FRAC, 14, output fraction bits; default format is Q2.14, so 1.0 = 0x4000.
- TAG_W, 4, sideband tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit accepts a sample this cycle.
- in_data  in  IN_W  x.
- in_mode  in  1  0 = sigmoid, 1 = tanh.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  y.
- out_tag  out  TAG_W  tag of the sample in out_data.

Behaviour:
- Reset (asynchronous, rst_n low): all stage valid bits clear; out_valid=0, out_data=0, out_tag=0. in_ready=1 while rst_n is low.
- Reset asserted mid-operation discards all in-flight samples.
- Pipeline: 3 register stages.
  - S1: sign, |x|, segment select.
  - S2: shift-add core.
  - S3: symmetry, mode mapping, output format.
- Latency: a sample accepted at edge N appears at out_data after edge N+3 when there is no stall.
- Handshake:
  - Transfer on valid & ready at both ports.
  - stall = out_valid & !out_ready; in_ready = !stall.
  - During a stall, all stages hold (global enable).
  - No bubble collapse is required.
  - out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Sigmoid core, on m = |x|, giving magnitude result p:
  - m < 1.0: p = m>>2 + 0.5
  - 1.0 <= m < 2.375: p = m>>3 + 0.625
  - 2.375 <= m < 5.0: p = m>>5 + 0.84375
  - m >= 5.0: p = 1.0
- Sign and mode mapping:
  - Sigmoid: y = p for x >= 0; y = 1.0 - p for x < 0.
  - Tanh: the core is evaluated at 2m. Segment thresholds are compared against m at half value: 0.5, 1.1875, 2.5. This avoids doubling overflow. t = 2p - 1.0; y = t for x >= 0, y = -t for x < 0.
- Arithmetic:
  - Computed at IN_FRAC precision with IN_W+2 bits of internal headroom.
  - Final conversion to OUT_FRAC truncates (drops the low IN_FRAC-OUT_FRAC bits of the non-negative magnitude) before applying sign/complement.
  - Output must never exceed +1.0 or go below -1.0 (tanh) or 0.0 (sigmoid).
- Boundaries:
  - x = 0x80000000 (most negative): |x| is not representable; treat as the saturated segment. Sigmoid gives 0x0000; tanh gives 0xC000.
  - Threshold values belong to the upper segment (m = 1.0 uses segment 2).
  - x = 0 gives 0x2000 (sigmoid) or 0x0000 (tanh).
- Mode and tag travel with their sample. Switching mode every cycle needs no flush.

Decomposition:
- Package plan_act_pkg holds:
  - mode enum (MODE_SIG = 0, MODE_TANH = 1);
  - segment-threshold and intercept localparams, expressed relative to IN_FRAC/OUT_FRAC;
  - stage payload struct {valid, sign, mode, seg, mag, tag}.
- One sub-module, plan_sig_core: purely combinational m -> p. It takes a mode input that selects the threshold set. It is instantiated once in S1/S2. Pipeline registers and the handshake stay in the top.

Test Plan:
- Sigmoid stream, out_ready=1, tags 0..7, inputs 0xFF800000, 0x01400000, 0x02800000, 0xFA C00000 -> outputs 0x1800, 0x3200, 0x3B00, 0x0000, each 3 cycles after acceptance, tags in order.
- Continue sigmoid with 0x00800000, 0xFEC00000, 0xFD800000, 0x05400000 -> 0x2800, 0x0E00, 0x0500, 0x4000.
- Tanh, mixed with sigmoid on alternate cycles:
  - x = 0x00800000 -> 0x2000; x = 0xFEC00000 -> 0xCA00; x = 0x03000000 -> 0x4000; x = 0xFD000000 -> 0xC000.
  - Interleaved sigmoid samples still match the earlier values.
- Back-pressure: stream 6 samples, drop out_ready for 4 cycles after the first output. Required: in_ready=0 throughout the stall, out_data/out_tag held stable, no loss or duplication, order preserved.
- Boundaries:
  - 0x80000000 -> 0x0000 (sigmoid) and 0xC000 (tanh).
  - 0x00000000 -> 0x2000 (sigmoid) and 0x0000 (tanh).
  - 0x01000000 -> 0x3000 (sigmoid).
  - 0x05000000 -> 0x4000 (sigmoid).
- Reset mid-stream: assert rst_n low asynchronously (between edges) with 3 samples in flight. Required: out_valid=0 and out_data=0 immediately; after release, no stale outputs; the next sample has latency 3.

Source files
------------

// File: rtl/plan_act_pkg.sv
// Shared widths, fixed-point constants and stage payload type for the
// piecewise-linear sigmoid/tanh activation pipeline.
package plan_act_pkg;

  localparam int IN_W     = 32;
  localparam int IN_FRAC  = 24;
  localparam int OUT_W    = 16;
  localparam int OUT_FRAC = 14;
  localparam int TAG_W    = 4;
  localparam int MAG_W    = IN_W + 2;
  localparam int DROP_W   = IN_FRAC - OUT_FRAC;

  typedef enum logic {
    MODE_SIG  = 1'b0,
    MODE_TANH = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    SEG_LIN0 = 2'd0,
    SEG_LIN1 = 2'd1,
    SEG_LIN2 = 2'd2,
    SEG_SAT  = 2'd3
  } seg_e;

  localparam logic [MAG_W-1:0] ONE_IN  = MAG_W'(1) << IN_FRAC;
  localparam logic [OUT_W-1:0] ONE_OUT = OUT_W'(1) << OUT_FRAC;

  // Tanh thresholds are the sigmoid ones halved, so 2m never has to be formed
  localparam logic [MAG_W-1:0] THR_SIG_1  = ONE_IN;
  localparam logic [MAG_W-1:0] THR_SIG_2  = MAG_W'(19) << (IN_FRAC - 3);
  localparam logic [MAG_W-1:0] THR_SIG_3  = MAG_W'(5) << IN_FRAC;
  localparam logic [MAG_W-1:0] THR_TANH_1 = MAG_W'(1) << (IN_FRAC - 1);
  localparam logic [MAG_W-1:0] THR_TANH_2 = MAG_W'(19) << (IN_FRAC - 4);
  localparam logic [MAG_W-1:0] THR_TANH_3 = MAG_W'(5) << (IN_FRAC - 1);

  localparam logic [MAG_W-1:0] P_INT0 = MAG_W'(1) << (IN_FRAC - 1);
  localparam logic [MAG_W-1:0] P_INT1 = MAG_W'(5) << (IN_FRAC - 3);
  localparam logic [MAG_W-1:0] P_INT2 = MAG_W'(27) << (IN_FRAC - 5);

  typedef struct packed {
    logic             valid;
    logic             sign;
    mode_e            mode;
    seg_e             seg;
    logic [MAG_W-1:0] mag;
    logic [TAG_W-1:0] tag;
  } stage_t;

endpackage

// File: rtl/plan_act_pipe_core.sv
// Combinational PLAN sigmoid core: segment select on the S1 side and
// shift-add evaluation on the S2 side, with per-sample threshold set.
module plan_sig_core
  import plan_act_pkg::*;
(
  input  mode_e            sel_mode_i,
  input  logic [MAG_W-1:0] sel_mag_i,
  output seg_e             sel_seg_o,
  input  mode_e            eval_mode_i,
  input  seg_e             eval_seg_i,
  input  logic [MAG_W-1:0] eval_mag_i,
  output logic [MAG_W-1:0] eval_p_o
);

  logic [MAG_W-1:0] thr1, thr2, thr3;
  logic [2:0]       halfShift;

  // Boundary values fall into the upper segment
  always_comb begin
    thr1 = THR_SIG_1;
    thr2 = THR_SIG_2;
    thr3 = THR_SIG_3;
    if (sel_mode_i == MODE_TANH) begin
      thr1 = THR_TANH_1;
      thr2 = THR_TANH_2;
      thr3 = THR_TANH_3;
    end
    if (sel_mag_i >= thr3)      sel_seg_o = SEG_SAT;
    else if (sel_mag_i >= thr2) sel_seg_o = SEG_LIN2;
    else if (sel_mag_i >= thr1) sel_seg_o = SEG_LIN1;
    else                        sel_seg_o = SEG_LIN0;
  end

  // Evaluating at 2m is the same as shifting m one place less
  always_comb begin
    halfShift = (eval_mode_i == MODE_TANH) ? 3'd1 : 3'd0;
    eval_p_o  = ONE_IN;
    case (eval_seg_i)
      SEG_LIN0: eval_p_o = (eval_mag_i >> (3'd2 - halfShift)) + P_INT0;
      SEG_LIN1: eval_p_o = (eval_mag_i >> (3'd3 - halfShift)) + P_INT1;
      SEG_LIN2: eval_p_o = (eval_mag_i >> (3'd5 - halfShift)) + P_INT2;
      default:  eval_p_o = ONE_IN;
    endcase
  end

endmodule

// File: rtl/plan_act_pipe.sv
// Three-stage sigmoid/tanh activation pipeline with valid/ready handshake,
// global-enable back-pressure and a pass-through tag.
module plan_act_pipe
  import plan_act_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  stage_t           s1_d, s1_q, s2_d, s2_q;
  logic             outValid_q;
  logic [OUT_W-1:0] outData_d, outData_q;
  logic [TAG_W-1:0] outTag_q;
  logic             stall, en;
  logic [MAG_W-1:0] inExt, inMag, coreP, mag3;
  logic [OUT_W-1:0] q3;
  seg_e             seg1;

  assign stall     = outValid_q & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_tag   = outTag_q;

  plan_sig_core u_core (
    .sel_mode_i  (mode_e'(in_mode)),
    .sel_mag_i   (inMag),
    .sel_seg_o   (seg1),
    .eval_mode_i (s1_q.mode),
    .eval_seg_i  (s1_q.seg),
    .eval_mag_i  (s1_q.mag),
    .eval_p_o    (coreP)
  );

  // Headroom makes |0x80000000| representable; it lands in the saturated segment
  always_comb begin
    inExt      = {{2{in_data[IN_W-1]}}, in_data};
    inMag      = in_data[IN_W-1] ? (~inExt + MAG_W'(1)) : inExt;
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.sign  = in_data[IN_W-1];
    s1_d.mode  = mode_e'(in_mode);
    s1_d.seg   = seg1;
    s1_d.mag   = inMag;
    s1_d.tag   = in_tag;
  end

  always_comb begin
    s2_d     = s1_q;
    s2_d.mag = coreP;
  end

  // Truncate the non-negative magnitude first, then apply symmetry
  always_comb begin
    mag3 = (s2_q.mode == MODE_TANH) ? ((s2_q.mag << 1) - ONE_IN) : s2_q.mag;
    q3   = (s2_q.seg == SEG_SAT) ? ONE_OUT : OUT_W'(mag3 >> DROP_W);
    if (!s2_q.sign)                 outData_d = q3;
    else if (s2_q.mode == MODE_TANH) outData_d = '0 - q3;
    else                            outData_d = ONE_OUT - q3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outTag_q   <= '0;
    end else if (en) begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      outValid_q <= s2_q.valid;
      outData_q  <= outData_d;
      outTag_q   <= s2_q.tag;
    end
  end

endmodule

// File: tb/tb_plan_act_pipe.sv
// Scoreboard bench for plan_act_pipe: directed vectors with fixed answers,
// then randomized traffic against an arithmetic reference model.
module tb_plan_act_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;

  plan_act_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
    int          acceptCyc;
    bit          latCheck;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic        mode;
    logic [15:0] y;
  } vec_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   randReady = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Sigmoid/tanh straight from the segment table, in units of 2^-24
  function automatic logic [15:0] refModel(input logic [31:0] x, input logic mode);
    longint one, xs, m, z, p, t, q, r;
    one = 64'sd1 << 24;
    xs  = longint'($signed(x));
    m   = (xs < 0) ? -xs : xs;
    z   = mode ? 2 * m : m;
    if (z >= 5 * one)             p = one;
    else if (z * 8 >= 19 * one)   p = z / 32 + (27 * one) / 32;
    else if (z >= one)            p = z / 8 + (5 * one) / 8;
    else                          p = z / 4 + one / 2;
    t = mode ? (2 * p - one) : p;
    q = t / 1024;
    if (xs < 0) r = mode ? -q : (16384 - q);
    else        r = q;
    return 16'(r);
  endfunction

  task automatic applyStimulus(input logic [31:0] x, input logic mode, input logic [3:0] tag,
                               input logic [15:0] expData, input bit latCheck);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = mode;
    in_tag   = tag;
    #4;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      e.data      = expData;
      e.tag       = tag;
      e.acceptCyc = cyc;
      e.latCheck  = latCheck;
      expQ.push_back(e);
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: samples just before each rising edge, pops on every output transfer
  initial begin
    bit          prevStall;
    logic [15:0] heldData;
    logic [3:0]  heldTag;
    exp_t        e;
    prevStall = 1'b0;
    heldData  = '0;
    heldTag   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        prevStall = 1'b0;
        continue;
      end
      if (prevStall) begin
        checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("stall_data", {16'b0, out_data}, {16'b0, heldData});
        checkOutput("stall_tag", {28'b0, out_tag}, {28'b0, heldTag});
      end
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
        heldData  = out_data;
        heldTag   = out_tag;
        prevStall = 1'b1;
      end else begin
        prevStall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_output: got data 0x%0h tag 0x%0h, required no output", out_data, out_tag);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", {16'b0, out_data}, {16'b0, e.data});
          checkOutput("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
          if (e.latCheck) checkOutput("latency", 32'(cyc - e.acceptCyc), 32'd3);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (randReady) out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[24] = '{
    '{32'hFF800000, 1'b0, 16'h1800}, '{32'h01400000, 1'b0, 16'h3200},
    '{32'h02800000, 1'b0, 16'h3B00}, '{32'hFAC00000, 1'b0, 16'h0000},
    '{32'h00800000, 1'b0, 16'h2800}, '{32'hFEC00000, 1'b0, 16'h0E00},
    '{32'hFD800000, 1'b0, 16'h0500}, '{32'h05400000, 1'b0, 16'h4000},
    '{32'h00800000, 1'b1, 16'h2000}, '{32'hFF800000, 1'b0, 16'h1800},
    '{32'hFEC00000, 1'b1, 16'hCA00}, '{32'h01400000, 1'b0, 16'h3200},
    '{32'h03000000, 1'b1, 16'h4000}, '{32'h02800000, 1'b0, 16'h3B00},
    '{32'hFD000000, 1'b1, 16'hC000}, '{32'hFAC00000, 1'b0, 16'h0000},
    '{32'h80000000, 1'b0, 16'h0000}, '{32'h80000000, 1'b1, 16'hC000},
    '{32'h00000000, 1'b0, 16'h2000}, '{32'h00000000, 1'b1, 16'h0000},
    '{32'h01000000, 1'b0, 16'h3000}, '{32'h05000000, 1'b0, 16'h4000},
    '{32'h02600000, 1'b0, 16'h3AC0}, '{32'h025FFFFF, 1'b0, 16'h3AFF}
  };

  function automatic logic [31:0] randX();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return $urandom_range(0, 32'h0C000000) - 32'h06000000;
  endfunction

  initial begin
    logic [31:0] x;
    logic        mode;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {16'b0, out_data}, 32'd0);
    checkOutput("reset_out_tag", {28'b0, out_tag}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] directed sigmoid/tanh/boundary vectors");
    foreach (vecs[i]) applyStimulus(vecs[i].x, vecs[i].mode, 4'(i), vecs[i].y, 1'b1);
    waitDrain();

    $display("[TB] back-pressure burst");
    fork
      for (int i = 0; i < 6; i++) begin
        x    = randX();
        mode = 1'($urandom_range(0, 1));
        applyStimulus(x, mode, 4'(8 + i), refModel(x, mode), 1'b0);
      end
      begin
        int waitCyc;
        waitCyc = 0;
        do begin
          @(negedge clk);
          #4;
          waitCyc++;
        end while (!(out_valid && out_ready) && waitCyc < 50);
        if (waitCyc >= 50) checkOutput("bp_first_output_timeout", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] randomized traffic with random out_ready");
    randReady = 1'b1;
    for (int i = 0; i < 80; i++) begin
      x    = randX();
      mode = 1'($urandom_range(0, 1));
      applyStimulus(x, mode, 4'($urandom_range(0, 15)), refModel(x, mode), 1'b0);
    end
    randReady = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    waitDrain();

    $display("[TB] asynchronous reset with samples in flight");
    for (int i = 0; i < 3; i++) begin
      x = randX();
      applyStimulus(x, 1'b0, 4'(i), refModel(x, 1'b0), 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async_reset_out_data", {16'b0, out_data}, 32'd0);
    checkOutput("async_reset_in_ready", {31'b0, in_ready}, 32'd1);
    expQ.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_reset_idle", {31'b0, out_valid}, 32'd0);
    end
    applyStimulus(32'h01400000, 1'b0, 4'hA, 16'h3200, 1'b1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
